// File: rtl/vga_framebuffer.sv
// 128x128 RGB444 frame store: CPU write port, 1-cycle display read port, hardware frame fill.
// Optional CPU readback port enabled by defining FB_READBACK_EN (default: cpu_rdata tied to 0).
module vga_framebuffer #(
  parameter int PX_BITS = 7,
  parameter int PY_BITS = 7,
  parameter int DATA_W  = 12,
  parameter int DEPTH   = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic [15:0]       vaddr,
  output logic [DATA_W-1:0] vdata
);

  localparam int AW = PX_BITS + PY_BITS;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     cnt, cnt_nxt;
  logic [DATA_W-1:0] color, color_nxt;
  logic              done_nxt;

  logic              we;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] wdata;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  assign cpu_ready = (state == IDLE) && !fill_start;
  assign fill_busy = (state == FILL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      color     <= '0;
      fill_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      color     <= color_nxt;
      fill_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    color_nxt = color;
    done_nxt  = 1'b0;
    we        = 1'b0;
    waddr     = cpu_addr[AW-1:0];
    wdata     = cpu_wdata;
    case (state)
      IDLE: begin
        if (fill_start) begin
          state_nxt = FILL;
          cnt_nxt   = '0;
          color_nxt = fill_color;
        end else if (cpu_we && cpu_addr[15:AW] == '0) begin
          we = !rst;
        end
      end
      FILL: begin
        we      = !rst;
        waddr   = cnt;
        wdata   = color;
        cnt_nxt = cnt + 1'b1;
        if (cnt == AW'(DEPTH - 1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single muxed write port; reads below sample before this edge's write (read-first).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      vdata <= '0;
    else if (vaddr[15:AW] == '0)  vdata <= mem[vaddr[AW-1:0]];
    else                          vdata <= '0;
  end

`ifdef FB_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        cpu_rdata <= '0;
    else if (cpu_addr[15:AW] == '0) cpu_rdata <= mem[cpu_addr[AW-1:0]];
    else                            cpu_rdata <= '0;
  end
`else
  assign cpu_rdata = '0;
`endif

endmodule

// File: tb/tb_vga_framebuffer.sv
// Directed bench for vga_framebuffer: reset, CPU write/display read, fill, collisions, reset mid-fill.
module tb_vga_framebuffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [11:0] cpu_wdata = '0;
  logic [11:0] cpu_rdata;
  logic        cpu_ready;
  logic        fill_start = 1'b0;
  logic [11:0] fill_color = '0;
  logic        fill_busy;
  logic        fill_done;
  logic [15:0] vaddr = '0;
  logic [11:0] vdata;

  int checks = 0;
  int errors = 0;

  vga_framebuffer dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .fill_start(fill_start), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .vaddr(vaddr), .vdata(vdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [11:0] d);
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic vread(input string tag, input logic [15:0] a, input logic [11:0] exp);
    vaddr = a;
    tick();
    check(tag, 32'(vdata), 32'(exp));
  endtask

  logic [11:0] rb_exp;
  int          n;
  logic        ready_seen;
  logic        done_seen;

  initial begin
    // Reset state, before any clock edge
    #2;
    check("rst_vdata", 32'(vdata), 0);
    check("rst_rdata", 32'(cpu_rdata), 0);
    check("rst_busy", 32'(fill_busy), 0);
    check("rst_done", 32'(fill_done), 0);
    check("rst_ready", 32'(cpu_ready), 1);
    tick();
    rst = 1'b0;
    tick();

    // CPU write then display read, 1-cycle latency
    cpu_write(16'h1234, 12'hF0A);
    vread("wr_1234", 16'h1234, 12'hF0A);

    // Out-of-range write dropped; out-of-range read gives 0
    cpu_write(16'h0234, 12'h123);
    cpu_write(16'h4234, 12'h777);
    vread("oor_wr_0234", 16'h0234, 12'h123);
    vread("oor_rd_4234", 16'h4234, 12'h000);

    // Read-first on same-address collision
    vaddr = 16'h0234;
    tick();
    cpu_we = 1'b1; cpu_addr = 16'h0234; cpu_wdata = 12'h456;
    tick();
    cpu_we = 1'b0;
    check("rdfirst_old", 32'(vdata), 32'h123);
    tick();
    check("rdfirst_new", 32'(vdata), 32'h456);

    // Readback port
    cpu_write(16'h0007, 12'hABC);
    cpu_addr = 16'h0007;
    tick();
`ifdef FB_READBACK_EN
    rb_exp = 12'hABC;
`else
    rb_exp = 12'h000;
`endif
    check("readback_7", 32'(cpu_rdata), 32'(rb_exp));

    // Prior data above the partial fill region
    cpu_write(16'd100, 12'h5A5);
    cpu_write(16'd200, 12'h5A5);

    // Reset mid-fill after 100 fill writes
    fill_start = 1'b1; fill_color = 12'h0F0;
    tick();
    fill_start = 1'b0;
    check("fill1_busy", 32'(fill_busy), 1);
    check("fill1_ready", 32'(cpu_ready), 0);
    for (int i = 0; i < 100; i++) tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(fill_busy), 0);
    check("midrst_done", 32'(fill_done), 0);
    check("midrst_vdata", 32'(vdata), 0);
    #1;
    rst = 1'b0;
    tick();
    check("midrst_nodone", 32'(fill_done), 0);
    vread("midrst_0", 16'd0, 12'h0F0);
    vread("midrst_99", 16'd99, 12'h0F0);
    vread("midrst_100", 16'd100, 12'h5A5);
    vread("midrst_200", 16'd200, 12'h5A5);

    // Full fill with simultaneous CPU write to address 5, and an ignored restart
    fill_start = 1'b1; fill_color = 12'h00F;
    cpu_we = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 12'h111;
    #1;
    check("collide_ready", 32'(cpu_ready), 0);
    tick();
    fill_start = 1'b0; cpu_we = 1'b0;
    n = 0;
    ready_seen = 1'b0;
    done_seen = 1'b0;
    while (fill_busy && n < 20000) begin
      if (cpu_ready) ready_seen = 1'b1;
      if (fill_done) done_seen = 1'b1;
      if (n == 50) begin
        fill_start = 1'b1; fill_color = 12'hFFF;
      end else begin
        fill_start = 1'b0;
      end
      n++;
      tick();
    end
    fill_start = 1'b0;
    check("fill_cycles", 32'(n), 32'd16384);
    check("fill_ready_low", 32'(ready_seen), 0);
    check("fill_no_early_done", 32'(done_seen), 0);
    check("fill_done_pulse", 32'(fill_done), 1);
    check("fill_busy_drop", 32'(fill_busy), 0);
    tick();
    check("fill_done_once", 32'(fill_done), 0);
    check("idle_ready", 32'(cpu_ready), 1);
    vread("fill_0", 16'd0, 12'h00F);
    vread("fill_5", 16'd5, 12'h00F);
    vread("fill_8191", 16'd8191, 12'h00F);
    vread("fill_16383", 16'd16383, 12'h00F);
    vread("fill_1234", 16'h1234, 12'h00F);

    // CPU writes resume after fill; out-of-range readback is 0
    cpu_write(16'h0010, 12'h3C3);
    vread("post_fill_wr", 16'h0010, 12'h3C3);
    cpu_addr = 16'h8007;
    tick();
    check("readback_oor", 32'(cpu_rdata), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_framebuffer.md
Name: vga_framebuffer

Overview:
- Dual-port 128x128x12-bit pixel store sitting directly upstream of the VGA timing/scan-out stage.
- The CPU side writes pixels through a memory-mapped port.
- The display side issues a 16-bit pixel address {py[6:0],px[6:0]} and receives 12-bit RGB444 one clock later.
- A hardware fill engine paints the whole frame with one colour, so software does not need 16384 stores to clear the screen.

Parameters:
- PX_BITS, 7, horizontal pixel index width (128 columns)
- PY_BITS, 7, vertical pixel index width (128 rows)
- DATA_W, 12, pixel width, RGB444 {r[3:0],g[3:0],b[3:0]}
- DEPTH, 16384, entries = 2^(PX_BITS+PY_BITS)

Ports:
- clk  in  1  system clock; both ports synchronous to it
- rst  in  1  asynchronous, active-high reset
- cpu_we  in  1  pixel write strobe, sampled when cpu_ready=1
- cpu_addr  in  16  CPU pixel address; bits [13:0] = {py,px}, bits [15:14] must be 0
- cpu_wdata  in  12  pixel value to write
- cpu_rdata  out  12  readback of cpu_addr (optional feature)
- cpu_ready  out  1  1 = CPU port accepts writes this cycle
- fill_start  in  1  single-cycle request to fill the frame
- fill_color  in  12  colour captured on an accepted fill_start
- fill_busy  out  1  fill engine active
- fill_done  out  1  one-cycle pulse after the last fill write
- vaddr  in  16  display read address {2'b00,py,px}
- vdata  out  12  registered display read data

Behaviour:
- Reset:
  - FSM=IDLE, fill counter=0, fill colour register=0.
  - vdata=0, cpu_rdata=0, fill_busy=0, fill_done=0.
  - RAM contents are not cleared.
- Display read:
  - vdata <= mem[vaddr[13:0]] on every clk edge; latency exactly 1 cycle.
  - The read is never stalled by CPU writes or the fill engine.
  - vaddr[15:14] nonzero -> vdata <= 0 on the next cycle.
- Same-address read during write (CPU or fill) returns OLD data (read-first).
- cpu_ready = (state==IDLE) && !fill_start (combinational).
- CPU write:
  - Occurs when cpu_we && cpu_ready && cpu_addr[15:14]==0; mem[cpu_addr[13:0]] <= cpu_wdata at that edge.
  - Out-of-range addresses are silently dropped.
  - A write attempted while cpu_ready=0 is dropped; software polls fill_busy before writing.
- FSM, states IDLE, FILL:
  - IDLE -> FILL on fill_start. Captures fill_color, clears counter to 0, fill_busy=1 from the next cycle.
  - FILL: writes mem[counter] <= colour each cycle, counter += 1 (14-bit).
  - FILL -> IDLE when a write occurs with counter==DEPTH-1. Total 16384 write cycles. fill_done=1 for the single cycle after that last write; fill_busy drops in the same cycle.
  - fill_start during FILL is ignored; no restart, colour unchanged.
- Simultaneous fill_start and cpu_we in IDLE: fill wins, CPU write dropped (cpu_ready=0 that cycle).
- Counter wraps 16383 -> 0 only at exit; never overruns.
- rst asserted mid-fill: immediate return to IDLE, fill_busy=0, no fill_done pulse. Already-written pixels keep the fill colour.
- Storage inferred as block RAM: one write port (muxed CPU/fill) and one read port for the display, plus the optional readback port.

Optional Feature:
- Macro FB_READBACK_EN.
- Defined:
  - cpu_rdata <= mem[cpu_addr[13:0]] each cycle; 1-cycle latency, read-first.
  - Out-of-range cpu_addr returns 0.
  - Valid during FILL as well (returns the current contents).
- Undefined:
  - cpu_rdata tied to 12'h000.
  - No third read port is inferred, saving a RAM copy.

Test Plan:
- Reset mid-stream: assert rst asynchronously while vaddr toggles -> vdata, cpu_rdata, fill_busy, fill_done read 0 immediately, without waiting for a clock edge.
- CPU write then display read: write 12'hF0A to cpu_addr 16'h1234, then vaddr=16'h1234 -> vdata=12'hF0A exactly 1 cycle after vaddr is applied. Out-of-range write to 16'h4234 -> vaddr 16'h0234 is unchanged.
- Fill: pulse fill_start with fill_color=12'h00F -> fill_busy=1 for 16384 cycles, then fill_done pulses once. Sampled vaddr 0, 8191, 16383 all return 12'h00F. cpu_ready=0 throughout.
- Collisions:
  - fill_start and cpu_we (addr 5, data 12'h111) in the same cycle -> addr 5 ends as fill colour.
  - Second fill_start mid-fill with 12'hFFF -> ignored; frame stays 12'h00F.
- Reset mid-fill: rst after 100 fill cycles -> IDLE, no fill_done. Addresses 0..99 hold the fill colour; address 100 and above keep their prior data.
- FB_READBACK_EN:
  - Defined: write 12'hABC at 16'h0007 -> cpu_rdata=12'hABC one cycle after presenting that address.
  - Undefined: cpu_rdata constantly 0.
